// File: rtl/u409_pkg.sv
// Shared encodings for the U409 68040 local-bus blocks: SIZ/TT/TM codes and
// the bus-master sequencing states.
package u409_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [1:0] TT_NORMAL    = 2'b00;
    localparam logic [2:0] TM_USER_DATA = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT,
        ST_END
    } state_t;

endpackage

// File: rtl/u409_bus_timeout.sv
// 8-bit transfer watchdog: cleared when a transfer starts, counts while the
// master waits, and flags expiry once TIMEOUT_CYCLES-1 idle edges have passed.
module u409_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    logic [7:0] count_reg;

    assign expire = (count_reg == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (en && !expire) begin
            count_reg <= count_reg + 8'd1;
        end
    end

endmodule

// File: rtl/u409_bus_master.sv
// Single-transfer 68040 local-bus initiator: arbitrates with BR/BG/BB, runs one
// TS/TIP cycle, and returns DONE or ERR plus read data to the on-card client.
module u409_bus_master
    import u409_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_LIMIT    = 3
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        REQ,
    input  logic        REQ_RNW,
    input  logic [31:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic [31:0] REQ_WDATA,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        BRn,
    input  logic        BGn,
    input  logic        BBn_IN,
    output logic        BBn_OUT,
    output logic        BB_OE,
    output logic        TSn,
    output logic        TIPn,
    output logic        RnW,
    output logic [1:0]  SIZ,
    output logic [1:0]  TT,
    output logic [2:0]  TM,
    output logic [31:0] A_OUT,
    output logic        ADDR_OE,
    output logic [31:0] D_OUT,
    input  logic [31:0] D_IN,
    output logic        D_OE,
    input  logic        TACKn,
    input  logic        TEAn
);

    state_t      state_reg, state_next;
    logic        rnw_reg, rnw_next;
    logic [31:0] addr_reg, addr_next;
    logic [1:0]  size_reg, size_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [7:0]  retry_reg, retry_next;
    logic        retrying_reg, retrying_next;

    logic        brn_reg, brn_next;
    logic        bbn_reg, bbn_next;
    logic        bb_oe_reg, bb_oe_next;
    logic        tsn_reg, tsn_next;
    logic        tipn_reg, tipn_next;
    logic        addr_oe_reg, addr_oe_next;
    logic        d_oe_reg, d_oe_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        rnw_out_reg, rnw_out_next;
    logic [1:0]  siz_reg, siz_next;
    logic [31:0] a_out_reg, a_out_next;
    logic [31:0] d_out_reg, d_out_next;
    logic [31:0] rdata_reg, rdata_next;

    logic        tmo_clear, tmo_en, tmo_expire;
    logic        terminate;

    u409_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK40),
        .rst_n  (RESETn),
        .clear  (tmo_clear),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    assign DONE    = done_reg;
    assign ERR     = err_reg;
    assign RDATA   = rdata_reg;
    assign BRn     = brn_reg;
    assign BBn_OUT = bbn_reg;
    assign BB_OE   = bb_oe_reg;
    assign TSn     = tsn_reg;
    assign TIPn    = tipn_reg;
    assign RnW     = rnw_out_reg;
    assign SIZ     = siz_reg;
    assign TT      = TT_NORMAL;
    assign TM      = TM_USER_DATA;
    assign A_OUT   = a_out_reg;
    assign ADDR_OE = addr_oe_reg;
    assign D_OUT   = d_out_reg;
    assign D_OE    = d_oe_reg;

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_reg    <= ST_IDLE;
            rnw_reg      <= 1'b1;
            addr_reg     <= 32'd0;
            size_reg     <= SIZ_LONG;
            wdata_reg    <= 32'd0;
            retry_reg    <= 8'd0;
            retrying_reg <= 1'b0;
            brn_reg      <= 1'b1;
            bbn_reg      <= 1'b1;
            bb_oe_reg    <= 1'b0;
            tsn_reg      <= 1'b1;
            tipn_reg     <= 1'b1;
            addr_oe_reg  <= 1'b0;
            d_oe_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rnw_out_reg  <= 1'b1;
            siz_reg      <= SIZ_LONG;
            a_out_reg    <= 32'd0;
            d_out_reg    <= 32'd0;
            rdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            rnw_reg      <= rnw_next;
            addr_reg     <= addr_next;
            size_reg     <= size_next;
            wdata_reg    <= wdata_next;
            retry_reg    <= retry_next;
            retrying_reg <= retrying_next;
            brn_reg      <= brn_next;
            bbn_reg      <= bbn_next;
            bb_oe_reg    <= bb_oe_next;
            tsn_reg      <= tsn_next;
            tipn_reg     <= tipn_next;
            addr_oe_reg  <= addr_oe_next;
            d_oe_reg     <= d_oe_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rnw_out_reg  <= rnw_out_next;
            siz_reg      <= siz_next;
            a_out_reg    <= a_out_next;
            d_out_reg    <= d_out_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Bus outputs are registered, so each is set on the edge that enters the
    // state it belongs to.
    always_comb begin
        state_next    = state_reg;
        rnw_next      = rnw_reg;
        addr_next     = addr_reg;
        size_next     = size_reg;
        wdata_next    = wdata_reg;
        retry_next    = retry_reg;
        retrying_next = retrying_reg;
        brn_next      = brn_reg;
        bbn_next      = bbn_reg;
        bb_oe_next    = bb_oe_reg;
        tsn_next      = tsn_reg;
        tipn_next     = tipn_reg;
        addr_oe_next  = addr_oe_reg;
        d_oe_next     = d_oe_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        rnw_out_next  = rnw_out_reg;
        siz_next      = siz_reg;
        a_out_next    = a_out_reg;
        d_out_next    = d_out_reg;
        rdata_next    = rdata_reg;
        tmo_clear     = 1'b0;
        tmo_en        = 1'b0;
        terminate     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (REQ) begin
                    if (REQ_SIZE == SIZ_LINE) begin
                        err_next = 1'b1;
                    end else begin
                        state_next    = ST_ARB;
                        rnw_next      = REQ_RNW;
                        addr_next     = REQ_ADDR;
                        size_next     = REQ_SIZE;
                        wdata_next    = REQ_WDATA;
                        retry_next    = 8'd0;
                        retrying_next = 1'b0;
                        brn_next      = 1'b0;
                    end
                end
            end
            ST_ARB: begin
                if (!BGn && BBn_IN) begin
                    state_next   = ST_START;
                    brn_next     = 1'b1;
                    bb_oe_next   = 1'b1;
                    bbn_next     = 1'b0;
                    addr_oe_next = 1'b1;
                    tsn_next     = 1'b0;
                    tipn_next    = 1'b0;
                    a_out_next   = addr_reg;
                    rnw_out_next = rnw_reg;
                    siz_next     = size_reg;
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
                tsn_next   = 1'b1;
                tmo_clear  = 1'b1;
                if (!rnw_reg) begin
                    d_oe_next  = 1'b1;
                    d_out_next = wdata_reg;
                end
            end
            ST_WAIT: begin
                retrying_next = 1'b0;
                if (!TACKn && TEAn) begin
                    terminate = 1'b1;
                    done_next = 1'b1;
                    if (rnw_reg) begin
                        rdata_next = D_IN;
                    end
                end else if (TACKn && !TEAn) begin
                    terminate = 1'b1;
                    err_next  = 1'b1;
                end else if (!TACKn && !TEAn) begin
                    terminate = 1'b1;
                    if (retry_reg < 8'(RETRY_LIMIT)) begin
                        retry_next    = retry_reg + 8'd1;
                        retrying_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (tmo_expire) begin
                    terminate = 1'b1;
                    err_next  = 1'b1;
                end else begin
                    tmo_en = 1'b1;
                end
                if (terminate) begin
                    state_next   = ST_END;
                    tipn_next    = 1'b1;
                    d_oe_next    = 1'b0;
                    bbn_next     = 1'b1;
                    addr_oe_next = 1'b0;
                end
            end
            ST_END: begin
                // BBn stays driven high for this one cycle before being released.
                bb_oe_next = 1'b0;
                if (retrying_reg) begin
                    state_next = ST_ARB;
                    brn_next   = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
